// File: rtl/design_select_sequencer_if.sv
// GPIO bank and per-design control lines between the select sequencer and the
// student design wrappers.
interface design_select_sequencer_if #(
    parameter int NUM_DESIGNS = 12,
    parameter int GPIO_W      = 34
);
    logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_out;
    logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_oeb;
    logic [GPIO_W-1:0]             gpio_out;
    logic [GPIO_W-1:0]             gpio_oeb;
    logic [NUM_DESIGNS-1:0]        designs_ncs;
    logic [NUM_DESIGNS-1:0]        designs_n_rst;

    modport master (
        input  designs_gpio_out, designs_gpio_oeb,
        output gpio_out, gpio_oeb, designs_ncs, designs_n_rst
    );

    modport slave (
        output designs_gpio_out, designs_gpio_oeb,
        input  gpio_out, gpio_oeb, designs_ncs, designs_n_rst
    );
endinterface

// File: rtl/design_select_sequencer.sv
// Sequenced design multiplexer: debounces design_select, resets and settles the
// incoming design, and only then routes its GPIO slice onto the pads.
module design_select_sequencer #(
    parameter int NUM_DESIGNS = 12,
    parameter int GPIO_W      = 34,
    parameter int SEL_W       = 4,
    parameter int DEBOUNCE    = 3,
    parameter int RST_HOLD    = 4,
    parameter int SETTLE      = 2
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [SEL_W-1:0]       design_select,
    input  logic                   soft_restart,
    design_select_sequencer_if.master bus,
    output logic [SEL_W-1:0]       active_sel,
    output logic                   busy
);
    localparam int CMAX  = (DEBOUNCE > RST_HOLD) ? ((DEBOUNCE > SETTLE) ? DEBOUNCE : SETTLE)
                                                 : ((RST_HOLD > SETTLE) ? RST_HOLD : SETTLE);
    localparam int CNT_W = $clog2(CMAX + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_QUALIFY, ST_RESET, ST_SETTLE, ST_ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, cand_q, cand_d, tgt_q, tgt_d, active_q, active_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   soft_q, busy_q, busy_d;
    logic [NUM_DESIGNS-1:0] ncs_q, ncs_d, nrst_q, nrst_d, tgt_hot;
    logic [GPIO_W-1:0]      pad_out, pad_oeb;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            soft_q   <= 1'b0;
            cand_q   <= '0;
            tgt_q    <= '0;
            cnt_q    <= '0;
            active_q <= '0;
            busy_q   <= 1'b0;
            ncs_q    <= '1;
            nrst_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= design_select;
            soft_q   <= soft_restart;
            cand_q   <= cand_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            ncs_q    <= ncs_d;
            nrst_q   <= nrst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (sel_q != active_q) begin
                    state_d = ST_QUALIFY;
                    cand_d  = sel_q;
                    cnt_d   = CNT_W'(1);
                end else if (state_q == ST_ACTIVE && soft_q) begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
            end
            ST_QUALIFY: begin
                if (sel_q != cand_q) begin
                    cand_d = sel_q;
                    cnt_d  = CNT_W'(1);
                end else if (cnt_q == CNT_W'(DEBOUNCE)) begin
                    // Select 0 and out-of-range values both mean "no design".
                    if (cand_q != '0 && cand_q <= SEL_W'(NUM_DESIGNS)) begin
                        state_d = ST_RESET;
                        tgt_d   = cand_q;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESET, ST_SETTLE: begin
                if (sel_q != tgt_q) begin
                    state_d = ST_QUALIFY;
                    cand_d  = sel_q;
                    cnt_d   = CNT_W'(1);
                end else if (state_q == ST_RESET && cnt_q == CNT_W'(RST_HOLD - 1)) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (state_q == ST_SETTLE && cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they register alongside it.
    always_comb begin
        tgt_hot = '0;
        for (int i = 0; i < NUM_DESIGNS; i++)
            tgt_hot[i] = (tgt_d == SEL_W'(i + 1));
        ncs_d    = '1;
        nrst_d   = '0;
        active_d = '0;
        busy_d   = 1'b0;
        case (state_d)
            ST_QUALIFY: busy_d = 1'b1;
            ST_RESET: begin
                ncs_d  = ~tgt_hot;
                busy_d = 1'b1;
            end
            ST_SETTLE: begin
                ncs_d  = ~tgt_hot;
                nrst_d = tgt_hot;
                busy_d = 1'b1;
            end
            ST_ACTIVE: begin
                ncs_d    = ~tgt_hot;
                nrst_d   = tgt_hot;
                active_d = tgt_d;
            end
            default: ;
        endcase
    end

    always_comb begin
        pad_out = '0;
        pad_oeb = '1;
        if (state_q == ST_ACTIVE) begin
            for (int i = 0; i < NUM_DESIGNS; i++) begin
                if (tgt_q == SEL_W'(i + 1)) begin
                    pad_out = bus.designs_gpio_out[i*GPIO_W +: GPIO_W];
                    pad_oeb = bus.designs_gpio_oeb[i*GPIO_W +: GPIO_W];
                end
            end
        end
    end

    assign bus.gpio_out      = pad_out;
    assign bus.gpio_oeb      = pad_oeb;
    assign bus.designs_ncs   = ncs_q;
    assign bus.designs_n_rst = nrst_q;
    assign active_sel        = active_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_design_select_sequencer.sv
// Directed bench for design_select_sequencer: select sequencing, bounce, invalid
// select, soft restart and mid-sequence reset.
module tb_design_select_sequencer;
    localparam int ND = 12;
    localparam int GW = 34;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [SW-1:0] design_select;
    logic          soft_restart;
    logic [SW-1:0] active_sel;
    logic          busy;
    int            vectors = 0;
    int            miscompares = 0;

    design_select_sequencer_if #(.NUM_DESIGNS(ND), .GPIO_W(GW)) bus ();

    design_select_sequencer #(
        .NUM_DESIGNS(ND), .GPIO_W(GW), .SEL_W(SW),
        .DEBOUNCE(3), .RST_HOLD(4), .SETTLE(2)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .design_select (design_select),
        .soft_restart  (soft_restart),
        .bus           (bus),
        .active_sel    (active_sel),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [GW-1:0] pat_out(input int d);
        return {d[1:0], d[7:0], 8'hC3, 8'(d * 3), 8'h5A};
    endfunction

    function automatic logic [GW-1:0] pat_oeb(input int d);
        return {~d[1:0], 8'h0F, d[7:0], 8'h33, 8'(d * 5)};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_rst = 1'b0; design_select = '0; soft_restart = 1'b0;
        tick(); tick();
        for (int r = 0; r < 2; r++) begin
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy r=%0d got %b want 0", r, busy); end
            vectors++; if (active_sel !== '0) begin miscompares++; $display("FAIL reset active_sel r=%0d got %0d want 0", r, active_sel); end
            vectors++; if (bus.designs_ncs !== '1) begin miscompares++; $display("FAIL reset ncs r=%0d got %b want all 1", r, bus.designs_ncs); end
            vectors++; if (bus.designs_n_rst !== '0) begin miscompares++; $display("FAIL reset n_rst r=%0d got %b want 0", r, bus.designs_n_rst); end
            vectors++; if (bus.gpio_out !== '0) begin miscompares++; $display("FAIL reset gpio_out r=%0d got %h want 0", r, bus.gpio_out); end
            vectors++; if (bus.gpio_oeb !== '1) begin miscompares++; $display("FAIL reset gpio_oeb r=%0d got %h want all 1", r, bus.gpio_oeb); end
            n_rst = 1'b1;
            tick(); tick(); tick();
        end
    endtask

    // Select d from IDLE; offset o counts edges from the edge sel_q first holds d.
    task automatic test_sequence(input int d);
        logic [ND-1:0] e_ncs, e_nrst;
        logic [GW-1:0] e_out, e_oeb;
        logic [SW-1:0] e_act;
        logic          e_busy;
        design_select = SW'(d);
        for (int i = 1; i <= 12; i++) begin
            int o;
            tick();
            o = i - 1;
            e_ncs = '1;  e_ncs[d-1]  = !(o >= 4);
            e_nrst = '0; e_nrst[d-1] = (o >= 8);
            e_busy = (o >= 1 && o <= 9);
            e_act  = (o >= 10) ? SW'(d) : '0;
            e_out  = (o >= 10) ? pat_out(d) : '0;
            e_oeb  = (o >= 10) ? pat_oeb(d) : '1;
            vectors++; if (bus.designs_ncs !== e_ncs) begin miscompares++; $display("FAIL seq%0d ncs o=%0d got %b want %b", d, o, bus.designs_ncs, e_ncs); end
            vectors++; if (bus.designs_n_rst !== e_nrst) begin miscompares++; $display("FAIL seq%0d n_rst o=%0d got %b want %b", d, o, bus.designs_n_rst, e_nrst); end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL seq%0d busy o=%0d got %b want %b", d, o, busy, e_busy); end
            vectors++; if (active_sel !== e_act) begin miscompares++; $display("FAIL seq%0d active_sel o=%0d got %0d want %0d", d, o, active_sel, e_act); end
            vectors++; if (bus.gpio_out !== e_out) begin miscompares++; $display("FAIL seq%0d gpio_out o=%0d got %h want %h", d, o, bus.gpio_out, e_out); end
            vectors++; if (bus.gpio_oeb !== e_oeb) begin miscompares++; $display("FAIL seq%0d gpio_oeb o=%0d got %h want %h", d, o, bus.gpio_oeb, e_oeb); end
        end
    endtask

    // From ACTIVE on 5: select 7,5,7 on consecutive edges, then 7 held.
    task automatic test_bounce();
        logic [ND-1:0] e_ncs, e_nrst;
        logic          e_busy;
        for (int i = 1; i <= 15; i++) begin
            int o;
            design_select = (i == 2) ? SW'(5) : SW'(7);
            tick();
            o = i - 3;
            if (i >= 2) begin
                e_ncs = '1;  e_ncs[6]  = !(o >= 4);
                e_nrst = '0; e_nrst[6] = (o >= 8);
                e_busy = (o <= 9);
                vectors++; if (bus.designs_ncs !== e_ncs) begin miscompares++; $display("FAIL bounce ncs o=%0d got %b want %b", o, bus.designs_ncs, e_ncs); end
                vectors++; if (bus.designs_n_rst !== e_nrst) begin miscompares++; $display("FAIL bounce n_rst o=%0d got %b want %b", o, bus.designs_n_rst, e_nrst); end
                vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL bounce busy o=%0d got %b want %b", o, busy, e_busy); end
                vectors++; if (active_sel !== ((o >= 10) ? SW'(7) : SW'(0))) begin miscompares++; $display("FAIL bounce active_sel o=%0d got %0d", o, active_sel); end
                vectors++; if (bus.gpio_oeb !== ((o >= 10) ? pat_oeb(7) : '1)) begin miscompares++; $display("FAIL bounce gpio_oeb o=%0d got %h", o, bus.gpio_oeb); end
            end
        end
    endtask

    // From ACTIVE on 7: select 13 (out of range) ends in IDLE with nothing on the pads.
    task automatic test_invalid();
        design_select = SW'(13);
        for (int i = 1; i <= 5; i++) begin
            int o;
            tick();
            o = i - 1;
            if (o == 0) begin
                vectors++; if (bus.gpio_out !== pat_out(7)) begin miscompares++; $display("FAIL invalid gpio_out o=0 got %h want %h", bus.gpio_out, pat_out(7)); end
                vectors++; if (active_sel !== SW'(7)) begin miscompares++; $display("FAIL invalid active_sel o=0 got %0d want 7", active_sel); end
            end else begin
                vectors++; if (bus.gpio_oeb !== '1) begin miscompares++; $display("FAIL invalid gpio_oeb o=%0d got %h want all 1", o, bus.gpio_oeb); end
                vectors++; if (bus.gpio_out !== '0) begin miscompares++; $display("FAIL invalid gpio_out o=%0d got %h want 0", o, bus.gpio_out); end
                vectors++; if (bus.designs_ncs !== '1) begin miscompares++; $display("FAIL invalid ncs o=%0d got %b want all 1", o, bus.designs_ncs); end
                vectors++; if (bus.designs_n_rst !== '0) begin miscompares++; $display("FAIL invalid n_rst o=%0d got %b want 0", o, bus.designs_n_rst); end
                vectors++; if (active_sel !== '0) begin miscompares++; $display("FAIL invalid active_sel o=%0d got %0d want 0", o, active_sel); end
                vectors++; if (busy !== (o <= 3)) begin miscompares++; $display("FAIL invalid busy o=%0d got %b want %b", o, busy, (o <= 3)); end
            end
        end
    endtask

    task automatic test_soft_restart();
        design_select = SW'(3);
        for (int i = 0; i < 14; i++) tick();
        vectors++; if (active_sel !== SW'(3)) begin miscompares++; $display("FAIL soft pre active_sel got %0d want 3", active_sel); end
        vectors++; if (bus.gpio_out !== pat_out(3)) begin miscompares++; $display("FAIL soft pre gpio_out got %h want %h", bus.gpio_out, pat_out(3)); end
        soft_restart = 1'b1;
        tick();
        soft_restart = 1'b0;
        vectors++; if (active_sel !== SW'(3)) begin miscompares++; $display("FAIL soft j active_sel got %0d want 3", active_sel); end
        for (int i = 1; i <= 7; i++) begin
            logic e_nrst;
            e_nrst = (i >= 5);
            tick();
            vectors++; if (bus.designs_n_rst[2] !== e_nrst) begin miscompares++; $display("FAIL soft n_rst3 j+%0d got %b want %b", i, bus.designs_n_rst[2], e_nrst); end
            vectors++; if (bus.designs_ncs[2] !== 1'b0) begin miscompares++; $display("FAIL soft ncs3 j+%0d got %b want 0", i, bus.designs_ncs[2]); end
            vectors++; if (busy !== (i <= 6)) begin miscompares++; $display("FAIL soft busy j+%0d got %b want %b", i, busy, (i <= 6)); end
            vectors++; if (bus.gpio_oeb !== ((i == 7) ? pat_oeb(3) : '1)) begin miscompares++; $display("FAIL soft gpio_oeb j+%0d got %h", i, bus.gpio_oeb); end
            vectors++; if (active_sel !== ((i == 7) ? SW'(3) : SW'(0))) begin miscompares++; $display("FAIL soft active_sel j+%0d got %0d", i, active_sel); end
        end
    endtask

    // Select 9, assert global reset in SETTLE, release and expect a full rerun.
    task automatic test_reset_mid_sequence();
        design_select = SW'(9);
        for (int i = 0; i < 9; i++) tick();
        vectors++; if (bus.designs_n_rst[8] !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL midrst settle n_rst9=%b busy=%b want 1 1", bus.designs_n_rst[8], busy); end
        n_rst = 1'b0;
        tick();
        vectors++; if (bus.designs_n_rst !== '0) begin miscompares++; $display("FAIL midrst n_rst got %b want 0", bus.designs_n_rst); end
        vectors++; if (bus.designs_ncs !== '1) begin miscompares++; $display("FAIL midrst ncs got %b want all 1", bus.designs_ncs); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst busy got %b want 0", busy); end
        vectors++; if (bus.gpio_oeb !== '1) begin miscompares++; $display("FAIL midrst gpio_oeb got %h want all 1", bus.gpio_oeb); end
        n_rst = 1'b1;
        test_sequence(9);
    endtask

    initial begin
        bus.designs_gpio_out = '0;
        bus.designs_gpio_oeb = '0;
        for (int d = 1; d <= ND; d++) begin
            bus.designs_gpio_out[(d-1)*GW +: GW] = pat_out(d);
            bus.designs_gpio_oeb[(d-1)*GW +: GW] = pat_oeb(d);
        end
        @(negedge clk);
        test_reset();
        test_sequence(5);
        test_bounce();
        test_invalid();
        test_soft_restart();
        test_reset_mid_sequence();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
